// File: rtl/irq_ctrl.sv
// irq_ctrl: prioritised, masked interrupt controller with single in-service tracking
module irq_ctrl #(
    parameter int          NIRQ      = 4,
    parameter logic [15:0] VEC_RESET = 16'h0010
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NIRQ-1:0] irq_in,
    input  logic [3:0]      state,
    input  logic            fault_r,
    input  logic            HLT,
    input  logic            SYSCALL,
    input  logic            RETI,
    input  logic            cfg_we,
    input  logic [1:0]      cfg_addr,
    input  logic [15:0]     cfg_wdata,
    output logic [15:0]     cfg_rdata,
    output logic            irq_r,
    output logic [2:0]      irq_id,
    output logic [15:0]     irq_vec
);
    localparam int N = NIRQ + 1;
    localparam logic [3:0] EXECM = 4'b1000;

    logic [NIRQ-1:0] sync1, sync2, sync3;
    logic [N-1:0]    mask, pend, pend_nx, eligible, set_ev, frz_oh;
    logic            gie, isv, ack, req, keep;
    logic [2:0]      isr_id, frz_id, sel_id;
    logic [15:0]     vec_base;
    logic            unused;

    assign unused  = ^cfg_wdata;
    assign irq_id  = irq_r ? frz_id : isv ? isr_id : sel_id;
    assign irq_vec = vec_base + {11'b0, irq_id, 2'b00};

    // two-flop synchroniser followed by an edge-history flop per line
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= irq_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    // priority select, request/acknowledge decode and next pending vector
    always_comb begin
        set_ev   = {SYSCALL, sync2 & ~sync3};
        eligible = pend & mask;
        sel_id   = '0;
        for (int i = NIRQ - 1; i >= 0; i--) sel_id = eligible[i] ? 3'(i) : sel_id;
        sel_id   = eligible[NIRQ] ? 3'(NIRQ) : sel_id;
        req      = gie & ~isv & |eligible;
        frz_oh   = N'(1) << frz_id;
        keep     = gie & |(eligible & frz_oh);
        ack      = irq_r & (state == 4'b0000) & ~fault_r & ~HLT;
        pend_nx  = (pend & ~(ack ? frz_oh : '0)
                         & ~((cfg_we && cfg_addr == 2'd1) ? cfg_wdata[N-1:0] : '0)) | set_ev;
    end

    // interrupt state, request handshake and configuration registers
    always_ff @(posedge clk) begin
        if (reset) begin
            mask     <= '0;
            pend     <= '0;
            gie      <= 1'b0;
            isv      <= 1'b0;
            isr_id   <= '0;
            frz_id   <= '0;
            irq_r    <= 1'b0;
            vec_base <= VEC_RESET;
        end else begin
            pend <= pend_nx;
            if (cfg_we && cfg_addr == 2'd0) mask <= cfg_wdata[N-1:0];
            if (cfg_we && cfg_addr == 2'd3) vec_base <= cfg_wdata;
            if (ack) begin
                isv    <= 1'b1;
                isr_id <= frz_id;
                gie    <= 1'b0;
                irq_r  <= 1'b0;
            end else begin
                if (RETI && isv) begin
                    isv <= 1'b0;
                    gie <= 1'b1;
                end else if (cfg_we && cfg_addr == 2'd2) begin
                    gie <= cfg_wdata[15];
                end
                if (irq_r) begin
                    irq_r <= keep;
                end else if (state == EXECM && req) begin
                    irq_r  <= 1'b1;
                    frz_id <= sel_id;
                end
            end
        end
    end

    // registered read port
    always_ff @(posedge clk) begin
        if (reset) cfg_rdata <= '0;
        else cfg_rdata <= cfg_addr == 2'd0 ? 16'(mask)
                        : cfg_addr == 2'd1 ? 16'(pend)
                        : cfg_addr == 2'd2 ? {gie, 6'b0, isv, 5'b0, isr_id}
                        : vec_base;
    end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: randomized scoreboard bench for irq_ctrl
module tb_irq_ctrl;
    localparam int NIRQ = 4;
    localparam logic [3:0] EXECM = 4'b1000;
    localparam logic [3:0] IDLE  = 4'b0101;

    logic            clk = 0, reset = 1;
    logic [NIRQ-1:0] irq_in = '0;
    logic [3:0]      state = IDLE;
    logic            fault_r = 0, HLT = 0, SYSCALL = 0, RETI = 0, cfg_we = 0;
    logic [1:0]      cfg_addr = '0;
    logic [15:0]     cfg_wdata = '0;
    logic [15:0]     cfg_rdata, irq_vec;
    logic            irq_r;
    logic [2:0]      irq_id;

    irq_ctrl #(.NIRQ(NIRQ), .VEC_RESET(16'h0010)) dut (
        .clk(clk), .reset(reset), .irq_in(irq_in), .state(state), .fault_r(fault_r),
        .HLT(HLT), .SYSCALL(SYSCALL), .RETI(RETI), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .irq_r(irq_r), .irq_id(irq_id),
        .irq_vec(irq_vec)
    );

    always #5 clk = ~clk;

    typedef struct { logic [2:0] id; logic [15:0] vec; } req_t;
    typedef struct { string name; logic [15:0] v; } rd_t;
    req_t req_q[$];
    rd_t  rd_q[$];
    int   cmp = 0, errs = 0;
    logic rd_req = 0, rd_vld = 0, prev_irq = 0;

    always @(posedge clk) rd_vld <= rd_req;

    task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
        cmp++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    // monitor: pops read and request expectations when the DUT presents them
    always @(negedge clk) begin : mon
        rd_t  r;
        req_t q;
        if (rd_vld) begin
            if (rd_q.size() == 0) chk("rd_underflow", 16'd1, 16'd0);
            else begin
                r = rd_q.pop_front();
                chk(r.name, cfg_rdata, r.v);
            end
        end
        if (irq_r && !prev_irq) begin
            if (req_q.size() == 0) chk("unexpected_req", 16'(irq_id), 16'hFFFF);
            else begin
                q = req_q.pop_front();
                chk("req_id", 16'(irq_id), 16'(q.id));
                chk("req_vec", irq_vec, q.vec);
            end
        end
        prev_irq <= irq_r;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        cfg_we = 1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [15:0] e, input string n);
        rd_t r;
        r.name = n; r.v = e;
        rd_q.push_back(r);
        cfg_addr = a; rd_req = 1;
        tick();
        rd_req = 0;
    endtask

    task automatic expect_req(input int id, input logic [15:0] vb);
        req_t q;
        q.id = 3'(id);
        q.vec = vb + 16'(id * 4);
        req_q.push_back(q);
    endtask

    task automatic pulse(input logic [NIRQ-1:0] l, input logic sy);
        irq_in = l; SYSCALL = sy;
        tick();
        irq_in = '0; SYSCALL = 0;
    endtask

    task automatic wait_irq(input string n);
        for (int i = 0; i < 8 && !irq_r; i++) tick();
        chk(n, 16'(irq_r), 16'd1);
    endtask

    task automatic serve();
        state = 4'b0000;
        tick();
        chk("ack_clr", 16'(irq_r), 16'd0);
        RETI = 1; state = IDLE;
        tick();
        RETI = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        reset = 0;
        chk("rst_irq_r", 16'(irq_r), 16'd0);
        chk("rst_irq_id", 16'(irq_id), 16'd0);
        chk("rst_vec", irq_vec, 16'h0010);
        rd(2'd0, 16'h0000, "rst_mask");
        rd(2'd1, 16'h0000, "rst_pend");
        rd(2'd2, 16'h0000, "rst_status");
        rd(2'd3, 16'h0010, "rst_vbase");

        wr(2'd0, 16'h0003);
        wr(2'd2, 16'h8000);
        state = EXECM;
        expect_req(1, 16'h0010);
        pulse(4'b0010, 0);
        tick();
        chk("lat2_no_req", 16'(irq_r), 16'd0);
        tick();
        chk("lat3_no_req", 16'(irq_r), 16'd0);
        rd(2'd1, 16'h0002, "pend_set");
        chk("req_up", 16'(irq_r), 16'd1);
        chk("req_id1", 16'(irq_id), 16'd1);
        chk("req_vec14", irq_vec, 16'h0014);
        state = 4'b0000;
        tick();
        chk("ack_irq_r", 16'(irq_r), 16'd0);
        chk("isr_id_out", 16'(irq_id), 16'd1);
        rd(2'd2, 16'h0101, "st_isv");
        rd(2'd1, 16'h0000, "pend_clr");
        RETI = 1; state = IDLE;
        tick();
        RETI = 0;
        rd(2'd2, 16'h8001, "st_reti");

        expect_req(0, 16'h0010);
        pulse(4'b0001, 0);
        state = EXECM;
        wait_irq("w1c_req");
        wr(2'd1, 16'h0001);
        tick();
        chk("w1c_drop", 16'(irq_r), 16'd0);
        state = 4'b0000;
        tick(); tick();
        rd(2'd2, 16'h8001, "w1c_noack");
        state = IDLE;

        expect_req(1, 16'h0010);
        pulse(4'b0010, 0);
        state = EXECM;
        wait_irq("flt_req");
        state = 4'b0000; fault_r = 1;
        tick(); tick();
        chk("fault_hold", 16'(irq_r), 16'd1);
        rd(2'd2, 16'h8001, "fault_noack");
        fault_r = 0; HLT = 1;
        tick(); tick();
        chk("hlt_hold", 16'(irq_r), 16'd1);
        rd(2'd2, 16'h8001, "hlt_noack");
        HLT = 0;
        tick();
        chk("ack_after_hlt", 16'(irq_r), 16'd0);
        rd(2'd2, 16'h0101, "st_after_hlt");
        RETI = 1; state = IDLE;
        tick();
        RETI = 0;

        expect_req(1, 16'h0010);
        pulse(4'b0010, 0);
        state = EXECM;
        wait_irq("co_req");
        irq_in = 4'b0010;
        tick();
        irq_in = '0;
        tick();
        state = 4'b0000;
        tick();
        chk("co_ack", 16'(irq_r), 16'd0);
        rd(2'd2, 16'h0101, "co_isv");
        rd(2'd1, 16'h0002, "co_pend");
        expect_req(1, 16'h0010);
        RETI = 1; state = IDLE;
        tick();
        RETI = 0; state = EXECM;
        wait_irq("co_rereq");
        serve();

        for (int s = 0; s < 8; s++) begin
            logic [4:0]      m, ev, el;
            logic [NIRQ-1:0] ln;
            logic            sy;
            logic [15:0]     vb;
            int              ids[$];
            m  = 5'($urandom);
            ln = NIRQ'($urandom);
            sy = 1'($urandom);
            vb = (s == 0) ? 16'hFFF8 : 16'($urandom);
            wr(2'd0, {11'b0, m});
            wr(2'd3, vb);
            wr(2'd2, 16'h8000);
            state = IDLE;
            pulse(ln, sy);
            repeat (3) tick();
            ev = {sy, ln};
            el = ev & m;
            ids.delete();
            if (el[NIRQ]) ids.push_back(NIRQ);
            for (int i = 0; i < NIRQ; i++) if (el[i]) ids.push_back(i);
            chk("idle_noreq", 16'(irq_r), 16'd0);
            chk("idle_id", 16'(irq_id), ids.size() ? 16'(ids[0]) : 16'd0);
            chk("idle_vec", irq_vec, vb + 16'((ids.size() ? ids[0] : 0) * 4));
            foreach (ids[k]) expect_req(ids[k], vb);
            foreach (ids[k]) begin
                state = EXECM;
                wait_irq("rnd_req");
                serve();
            end
            state = EXECM;
            repeat (3) tick();
            chk("drained", 16'(irq_r), 16'd0);
            rd(2'd1, {11'b0, ev & ~m}, "leftover");
            wr(2'd1, 16'hFFFF);
            state = IDLE;
        end

        wr(2'd0, 16'h0003);
        wr(2'd2, 16'h8000);
        wr(2'd3, 16'h1234);
        expect_req(0, 16'h1234);
        pulse(4'b0001, 0);
        state = EXECM;
        wait_irq("pre_rst");
        reset = 1;
        tick();
        reset = 0; state = IDLE;
        chk("rst_mid_irq_r", 16'(irq_r), 16'd0);
        rd(2'd0, 16'h0000, "rst2_mask");
        rd(2'd1, 16'h0000, "rst2_pend");
        rd(2'd2, 16'h0000, "rst2_status");
        rd(2'd3, 16'h0010, "rst2_vbase");

        tick(); tick();
        chk("rdq_empty", 16'(rd_q.size()), 16'd0);
        chk("reqq_empty", 16'(req_q.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Interrupt controller for the microcoded CPU.
- Collects peripheral interrupt lines and the SYSCALL software request, prioritises and masks them, and raises irq_r to the decoder only at an instruction boundary (decoder state EXECM).
- Tracks the single in-service interrupt until RETI.
- Exposes a small register file for mask, pending, status and vector base.

Parameters:
- NIRQ, 4: number of hardware interrupt lines, 1..7. Software interrupt occupies id NIRQ.
- VEC_RESET, 16'h0010: reset value of the vector base register.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  reset, synchronous, active-high.
- irq_in  input  NIRQ  asynchronous level lines from peripherals.
- state  input  4  decoder FSM state (EXECM = 4'b1000, interrupt entry = 4'b0000).
- fault_r  input  1  decoder fault flag; blocks acknowledge.
- HLT  input  1  decoder halt flag; blocks acknowledge.
- SYSCALL  input  1  microcode syscall strobe.
- RETI  input  1  microcode return-from-interrupt strobe.
- cfg_we  input  1  register write strobe.
- cfg_addr  input  2  register select.
- cfg_wdata  input  16  write data.
- cfg_rdata  output  16  registered read data.
- irq_r  output  1  interrupt request to decoder.
- irq_id  output  3  id of the requested or in-service interrupt.
- irq_vec  output  16  handler address = vec_base + (irq_id << 2), 16-bit wrap.

Behaviour:
- Reset values: mask 0, pend 0, gie 0, isv 0, isr_id 0, vec_base = VEC_RESET, sync flops 0, irq_r 0, cfg_rdata 0.
- Input path:
  - irq_in passes through a 2-FF synchroniser plus one edge flop.
  - A rising edge sets pend[i] on the following posedge, 3 cycles after the input change.
  - A level held high sets pend only once.
- SYSCALL high at a posedge sets pend[NIRQ].
- eligible = pend & mask. Priority: highest id = software (NIRQ), then lowest hardware index first.
- Request condition req = gie & ~isv & |eligible.
- irq_r behaviour:
  - Set at the posedge where state == EXECM and req holds.
  - While irq_r = 1, irq_id is frozen to the selected id.
  - irq_r clears on the next posedge if the frozen id's eligible bit drops, or gie drops.
  - irq_r is never set in any state other than EXECM.
- Acknowledge: posedge with irq_r = 1, state == 0, fault_r = 0, HLT = 0. Same edge:
  - pend[irq_id] clears; a coincident new edge on that line wins and leaves it set.
  - isv <= 1, isr_id <= irq_id, gie <= 0, irq_r <= 0.
- fault_r or HLT with state 0: no acknowledge; irq_r holds if req still true.
- RETI with isv = 1: isv <= 0, gie <= 1. RETI with isv = 0: ignored.
- irq_id output: frozen id while irq_r = 1; isr_id while isv = 1; otherwise the current highest-priority eligible id (0 if none).
- Register map, all reads registered (1-cycle latency):
  - addr 0 MASK: rw, bits [NIRQ:0]; upper bits read 0.
  - addr 1 PEND: read; write-1-to-clear. A set event in the same cycle wins over the clear.
  - addr 2 STATUS: bit15 gie (rw), bit8 isv (ro), bits[2:0] isr_id (ro). Writing bit15 also updates gie. A same-cycle acknowledge wins over the write.
  - addr 3 VBASE: rw, 16 bits.
- Nesting is not supported: no request while isv = 1. Pending events remain latched.
- Reset mid-request or mid-service: all state returns to reset values in one cycle, and pending events are lost.

Test Plan:
- Reset, then MASK=0x3, STATUS bit15=1, pulse irq_in[1] high, hold state=EXECM -> pend=0x2 after 3 cycles; irq_r=1 next posedge; irq_id=1; irq_vec=0x0014.
- Drive state=0 with irq_r=1 -> same posedge pend=0, isv=1, gie=0, irq_r=0. Then RETI pulse -> isv=0, gie=1.
- irq_in[0] and irq_in[2] edges together, mask=0x5, SYSCALL with mask bit NIRQ set -> ids served in order 4, 0, 2 across three acknowledge/RETI cycles.
- irq_r high, then W1C PEND bit of the frozen id -> irq_r=0 next posedge. State=0 afterwards -> no acknowledge, isv stays 0.
- irq_r high, state=0 with fault_r=1 -> no acknowledge and irq_r held. Same with HLT=1.
- Ack edge coincides with a new edge on the same line -> pend bit remains 1 and isv=1. After RETI, a second request on the same id is issued at the next EXECM.
